// File: rtl/router_pkt_tx_if.sv
// Router link between the packet transmitter and the router receiver.
// The master side drives pkt_valid and data_out; the slave side drives rtr_busy.
interface router_pkt_tx_if;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       rtr_busy;

    modport master (output pkt_valid, output data_out, input rtr_busy);
    modport slave  (input pkt_valid, input data_out, output rtr_busy);
endinterface

// File: rtl/router_pkt_tx.sv
// Packet transmitter: 16x8 payload FIFO feeding a header/payload/parity framer toward the router.
// Optional ROUTER_TX_PARITY_INJECT_EN adds inject_par, which inverts the transmitted parity byte.
//
// state   | meaning
// IDLE    | waiting for start; a bad start pulses err
// WAIT    | packet accepted, waiting for router ready and enough payload
// HDR     | header byte on the link
// PAYLOAD | popping len payload bytes onto the link
// PARITY  | XOR of header and payload on the link
// GAP     | two idle link cycles, done in the first
module router_pkt_tx (
    input  logic           clk,
    input  logic           resetn,
    input  logic           wr_en,
    input  logic [7:0]     wr_data,
    output logic [4:0]     fifo_count,
    output logic           fifo_full,
    input  logic           start,
    input  logic [1:0]     dest,
    input  logic [3:0]     len,
`ifdef ROUTER_TX_PARITY_INJECT_EN
    input  logic           inject_par,
`endif
    router_pkt_tx_if.master rtr,
    output logic           tx_busy,
    output logic           done,
    output logic           err
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_HDR, S_PAYLOAD, S_PARITY, S_GAP
    } state_t;

    state_t      state;
    logic [7:0]  mem [16];
    logic [3:0]  wr_ptr;
    logic [3:0]  rd_ptr;
    logic [1:0]  dest_q;
    logic [3:0]  len_q;
    logic [3:0]  remain;
    logic [7:0]  par;
    logic [7:0]  par_tx;
    logic        gap2;
    logic        push;
    logic        pop;
    logic [7:0]  rd_byte;
    logic [7:0]  hdr;

    assign fifo_full = (fifo_count == 5'd16);
    assign push      = wr_en && !fifo_full;
    // WAIT only releases once len bytes are present, so pops never underflow
    assign pop       = (state == S_HDR) || ((state == S_PAYLOAD) && (remain != 4'd0));
    assign rd_byte   = mem[rd_ptr];
    assign hdr       = {2'b00, len_q, dest_q};
    assign tx_busy   = (state != S_IDLE);

`ifdef ROUTER_TX_PARITY_INJECT_EN
    logic inj_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            inj_q <= 1'b0;
        else if (state == S_IDLE && start)
            inj_q <= inject_par;
    end

    assign par_tx = inj_q ? ~par : par;
`else
    assign par_tx = par;
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= 4'd0;
            rd_ptr     <= 4'd0;
            fifo_count <= 5'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 4'd1;
            if (pop)
                rd_ptr <= rd_ptr + 4'd1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 5'd1;
                2'b01:   fifo_count <= fifo_count - 5'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            dest_q        <= 2'd0;
            len_q         <= 4'd0;
            remain        <= 4'd0;
            par           <= 8'h00;
            gap2          <= 1'b0;
            rtr.pkt_valid <= 1'b0;
            rtr.data_out  <= 8'h00;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len == 4'd0 || dest == 2'd3) begin
                            err <= 1'b1;
                        end else begin
                            dest_q <= dest;
                            len_q  <= len;
                            state  <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!rtr.rtr_busy && fifo_count >= {1'b0, len_q}) begin
                        state         <= S_HDR;
                        rtr.pkt_valid <= 1'b1;
                        rtr.data_out  <= hdr;
                        par           <= hdr;
                    end
                end
                S_HDR: begin
                    state        <= S_PAYLOAD;
                    rtr.data_out <= rd_byte;
                    par          <= par ^ rd_byte;
                    remain       <= len_q - 4'd1;
                end
                S_PAYLOAD: begin
                    if (remain != 4'd0) begin
                        rtr.data_out <= rd_byte;
                        par          <= par ^ rd_byte;
                        remain       <= remain - 4'd1;
                    end else begin
                        state        <= S_PARITY;
                        rtr.data_out <= par_tx;
                    end
                end
                S_PARITY: begin
                    state         <= S_GAP;
                    rtr.pkt_valid <= 1'b0;
                    rtr.data_out  <= 8'h00;
                    done          <= 1'b1;
                    gap2          <= 1'b0;
                end
                S_GAP: begin
                    if (!gap2)
                        gap2 <= 1'b1;
                    else
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomized bench for router_pkt_tx against a queue-based packet model.
// Define ROUTER_TX_PARITY_INJECT_EN for both RTL and bench to cover parity inversion.
module tb_router_pkt_tx;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       start = 1'b0;
    logic [1:0] dest = 2'd0;
    logic [3:0] len = 4'd0;
`ifdef ROUTER_TX_PARITY_INJECT_EN
    logic       inject_par = 1'b0;
`endif
    logic [4:0] fifo_count;
    logic       fifo_full;
    logic       tx_busy;
    logic       done;
    logic       err;

    router_pkt_tx_if rif();

    router_pkt_tx dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .start      (start),
        .dest       (dest),
        .len        (len),
`ifdef ROUTER_TX_PARITY_INJECT_EN
        .inject_par (inject_par),
`endif
        .rtr        (rif.master),
        .tx_busy    (tx_busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] q[$];
    logic [1:0] d_q;
    logic [3:0] l_q;
    logic       ip_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en = 1'b0;
        if (q.size() < 16)
            q.push_back(b);
        chk("fifo_count", fifo_count, q.size());
        chk("fifo_full", fifo_full, (q.size() == 16));
    endtask

    task automatic start_pkt(input logic [1:0] d, input logic [3:0] l, input logic ip);
        dest  = d;
        len   = l;
`ifdef ROUTER_TX_PARITY_INJECT_EN
        inject_par = ip;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        if (l == 4'd0 || d == 2'd3) begin
            chk("err_pulse", err, 1);
            chk("err_busy", tx_busy, 0);
            chk("err_valid", rif.pkt_valid, 0);
            tick();
            chk("err_clear", err, 0);
            chk("err_idle", tx_busy, 0);
        end else begin
            chk("accept_busy", tx_busy, 1);
            chk("accept_noerr", err, 0);
            d_q  = d;
            l_q  = l;
            ip_q = ip;
        end
    endtask

    // k = cycles the router stays busy after start; poke = pulse start mid-packet
    task automatic send_expect(input int k, input bit poke);
        logic [7:0] exp[$];
        logic [7:0] p;
        logic [7:0] b;
        int         n;
        exp.push_back({2'b00, l_q, d_q});
        p = exp[0];
        for (int i = 0; i < int'(l_q); i++) begin
            b = q.pop_front();
            exp.push_back(b);
            p = p ^ b;
        end
        if (ip_q)
            p = ~p;
        exp.push_back(p);
        n = 0;
        rif.rtr_busy = (k > 0);
        while (!rif.pkt_valid && n < 40) begin
            if (n == k)
                rif.rtr_busy = 1'b0;
            tick();
            n++;
        end
        chk("hdr_latency", n, k + 1);
        for (int i = 0; i < exp.size(); i++) begin
            chk("pkt_valid", rif.pkt_valid, 1);
            chk("pkt_byte", rif.data_out, exp[i]);
            rif.rtr_busy = 1'($urandom_range(0, 1));
            start = poke && (i == 1);
            tick();
        end
        start = 1'b0;
        rif.rtr_busy = 1'b0;
        chk("done_pulse", done, 1);
        chk("gap_valid", rif.pkt_valid, 0);
        chk("gap_data", rif.data_out, 0);
        chk("fifo_after", fifo_count, q.size());
        tick();
        chk("done_clear", done, 0);
        chk("gap2_busy", tx_busy, 1);
        chk("gap2_data", rif.data_out, 0);
        tick();
        chk("idle_busy", tx_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int nb;
        int mx;
        rif.rtr_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", fifo_count, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_valid", rif.pkt_valid, 0);
        chk("rst_data", rif.data_out, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // basic packet
        push(8'hA5);
        push(8'h3C);
        start_pkt(2'd1, 4'd2, 1'b0);
        send_expect(0, 1'b0);

        // rejected starts
        start_pkt(2'd1, 4'd0, 1'b0);
        start_pkt(2'd3, 4'd5, 1'b0);

        // waiting on router busy and on FIFO depth
        push(8'h11);
        start_pkt(2'd2, 4'd3, 1'b0);
        rif.rtr_busy = 1'b1;
        repeat (3) begin
            tick();
            chk("wait_busy", tx_busy, 1);
            chk("wait_valid", rif.pkt_valid, 0);
        end
        push(8'h22);
        push(8'h33);
        chk("wait_still", rif.pkt_valid, 0);
        send_expect(0, 1'b0);

        // full FIFO, dropped write, wrap-around read
        for (int i = 0; i < 17; i++)
            push(8'h40 + 8'(i));
        start_pkt(2'd0, 4'd15, 1'b0);
        send_expect(2, 1'b1);

        // reset in the middle of a payload
        for (int i = 0; i < 6; i++)
            push(8'($urandom));
        start_pkt(2'd0, 4'd5, 1'b0);
        nb = 0;
        while (!rif.pkt_valid && nb < 20) begin
            tick();
            nb++;
        end
        tick();
        tick();
        chk("mid_valid", rif.pkt_valid, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_valid", rif.pkt_valid, 0);
        chk("arst_data", rif.data_out, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_busy", tx_busy, 0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        push(8'h5A);
        push(8'hC3);
        start_pkt(2'd2, 4'd2, 1'b0);
        send_expect(0, 1'b0);

`ifdef ROUTER_TX_PARITY_INJECT_EN
        push(8'hA5);
        push(8'h3C);
        start_pkt(2'd1, 4'd2, 1'b1);
        send_expect(0, 1'b0);
`endif

        for (int it = 0; it < 30; it++) begin
            nb = $urandom_range(0, 5);
            for (int j = 0; j < nb; j++)
                push(8'($urandom));
            if ($urandom_range(0, 4) == 0 || q.size() == 0) begin
                if ($urandom_range(0, 1) == 1)
                    start_pkt(2'd3, 4'($urandom_range(0, 15)), 1'b0);
                else
                    start_pkt(2'($urandom_range(0, 3)), 4'd0, 1'b0);
            end else begin
                mx = (q.size() > 15) ? 15 : q.size();
`ifdef ROUTER_TX_PARITY_INJECT_EN
                start_pkt(2'($urandom_range(0, 2)), 4'($urandom_range(1, mx)), 1'($urandom_range(0, 1)));
`else
                start_pkt(2'($urandom_range(0, 2)), 4'($urandom_range(1, mx)), 1'b0);
`endif
                send_expect($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-003 SHALL have port wr_en  input  1  push wr_data into payload FIFO.
REQ-004 SHALL have port wr_data  input  8  payload byte.
REQ-005 SHALL have port fifo_count  output  5  payload FIFO occupancy, 0..16.
REQ-006 SHALL have port fifo_full  output  1  high when fifo_count==16.
REQ-007 SHALL have port start  input  1  one-cycle request to send a packet.
REQ-008 SHALL have port dest  input  2  destination channel, sampled with start.
REQ-009 SHALL have port len  input  4  payload length in bytes, sampled with start.
REQ-010 SHALL have port rtr_busy  input  1  busy flag from the router receiver.
REQ-011 SHALL have port pkt_valid  output  1  packet framing strobe to router.
REQ-012 SHALL have port data_out  output  8  packet byte to router.
REQ-013 SHALL have port tx_busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the parity byte.
REQ-015 SHALL have port err  output  1  one-cycle pulse on a rejected start.

Function
REQ-016 Payload FIFO SHALL be 16x8, circular, 4-bit pointers wrapping 15->0; write when full SHALL be dropped; simultaneous push and pop SHALL leave count unchanged.
REQ-017 FSM states SHALL be IDLE, WAIT, HDR, PAYLOAD, PARITY, GAP.
REQ-018 IDLE: start with len==0 or dest==3 SHALL pulse err next cycle and remain IDLE; otherwise latch dest/len, go WAIT; start outside IDLE SHALL be ignored.
REQ-019 WAIT: SHALL move to HDR when rtr_busy==0 and fifo_count>=latched len; otherwise hold.
REQ-020 HDR: data_out SHALL be {2'b00, len, dest}, pkt_valid=1; parity accumulator SHALL load header; go PAYLOAD.
REQ-021 PAYLOAD: each cycle SHALL pop one FIFO byte onto data_out with pkt_valid=1 and XOR it into parity; after len bytes go PARITY.
REQ-022 PARITY: data_out SHALL be accumulated XOR of header and all payload bytes, pkt_valid=1; go GAP.
REQ-023 GAP: pkt_valid=0, data_out=0x00 for exactly 2 cycles, done pulses in first GAP cycle, then IDLE.
REQ-024 data_out and pkt_valid SHALL be registered; pkt_valid SHALL stay high contiguously for len+2 cycles per packet.
REQ-025 Outside HDR/PAYLOAD/PARITY, pkt_valid SHALL be 0 and data_out 0x00.
REQ-026 rtr_busy SHALL be ignored once HDR is entered.
REQ-027 Minimum start-to-header latency SHALL be 2 cycles (IDLE->WAIT->HDR).

Reset
REQ-028 resetn low SHALL immediately force IDLE, FIFO pointers/count to 0, pkt_valid=0, data_out=0x00, tx_busy=0, done=0, err=0, fifo_full=0.
REQ-029 Reset mid-packet SHALL abort without emitting parity; FIFO contents SHALL be discarded.
REQ-030 FIFO storage need not be reset; no X SHALL reach data_out.

Configuration
REQ-031 Macro ROUTER_TX_PARITY_INJECT_EN SHALL, when defined, add input inject_par (1 bit) sampled with start; when set, transmitted parity byte SHALL be bitwise-inverted.
REQ-032 Without ROUTER_TX_PARITY_INJECT_EN the port SHALL not exist and parity SHALL always be correct.

Verification
REQ-033 Push 0xA5,0x3C; start dest=1 len=2, rtr_busy=0 -> pkt_valid 4 cycles, data_out 0x09,0xA5,0x3C,0x90; done pulse; fifo_count 0.
REQ-034 start len=0 or dest=3 -> err pulse one cycle, pkt_valid stays 0, tx_busy 0.
REQ-035 start dest=2 len=3 with 1 byte in FIFO, rtr_busy=1 -> holds WAIT; push 2 bytes, drop rtr_busy -> header 0x0E sent 1 cycle later.
REQ-036 Push 17 bytes -> fifo_full after 16th, 17th dropped; len=15 packet then sends 15 bytes in order across pointer wrap.
REQ-037 Assert resetn low during PAYLOAD -> pkt_valid 0 same cycle, fifo_count 0, next start sends correct packet.
REQ-038 With ROUTER_TX_PARITY_INJECT_EN, repeat REQ-033 with inject_par=1 -> parity byte 0x6F.
